// File: rtl/pipeline_stall_controller.sv
// Front-end controller for the 5-stage MIPS core: PC, IF/ID register, stall/flush/mem-wait sequencing.
// Optional macro PERF_CNT_EN builds the saturating stall/flush/mem-wait performance counters.
module pipeline_stall_controller #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MAX_STALL = 15,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCWrite,
   input  logic             IFIDWrite,
   input  logic             setZero,
   input  logic             branchTaken,
   input  logic [31:0]      branchTarget,
   input  logic             memBusy,
   input  logic [31:0]      instIn,
   output logic [31:0]      pc,
   output logic [31:0]      ifidInst,
   output logic [31:0]      ifidPcPlus4,
   output logic             ifidValid,
   output logic             bubble,
   output logic             freeze,
   output logic [1:0]       stateOut,
   output logic             stallTimeout,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount,
   output logic [CNT_W-1:0] memWaitCycles
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_FLUSH   = 2'd3
   } state_e;

   localparam int              RL_W   = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
   localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);

   logic [31:0]     pc_q, pc_d;
   logic [31:0]     ifid_inst_q, ifid_inst_d;
   logic [31:0]     ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic            ifid_valid_q, ifid_valid_d;
   state_e          state_q, state_d;
   logic [RL_W-1:0] run_len_q, run_len_d;
   logic            timeout_q, timeout_d;
   logic [31:0]     pc_plus4;

   // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
   always_comb begin
      pc_plus4        = pc_q + 32'd4;
      pc_d            = pc_q;
      ifid_inst_d     = ifid_inst_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_valid_d    = ifid_valid_q;
      state_d         = state_q;
      run_len_d       = '0;
      timeout_d       = timeout_q;

      if (memBusy) begin
         // Whole front end holds; a pending redirect is re-presented by EX once memory is ready.
         state_d = ST_MEMWAIT;
      end else if (branchTaken) begin
         pc_d            = branchTarget;
         ifid_inst_d     = '0;
         ifid_pc_plus4_d = '0;
         ifid_valid_d    = 1'b0;
         state_d         = ST_FLUSH;
      end else if (!PCWrite || !IFIDWrite) begin
         if (PCWrite) begin
            pc_d = pc_plus4;
         end
         if (IFIDWrite) begin
            ifid_inst_d     = instIn;
            ifid_pc_plus4_d = pc_plus4;
            ifid_valid_d    = 1'b1;
         end
         state_d   = ST_LDSTALL;
         run_len_d = (run_len_q == RL_MAX) ? RL_MAX : run_len_q + RL_W'(1);
         if (run_len_d == RL_MAX) begin
            timeout_d = 1'b1;
         end
      end else begin
         pc_d            = pc_plus4;
         ifid_inst_d     = instIn;
         ifid_pc_plus4_d = pc_plus4;
         ifid_valid_d    = 1'b1;
         state_d         = ST_RUN;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q            <= RESET_PC;
         ifid_inst_q     <= '0;
         ifid_pc_plus4_q <= '0;
         ifid_valid_q    <= 1'b0;
         state_q         <= ST_RUN;
         run_len_q       <= '0;
         timeout_q       <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         ifid_inst_q     <= ifid_inst_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
         ifid_valid_q    <= ifid_valid_d;
         state_q         <= state_d;
         run_len_q       <= run_len_d;
         timeout_q       <= timeout_d;
      end
   end

`ifdef PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

   // Each counter advances on edges entering its state and sticks at all-ones.
   always_comb begin
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      memwait_cnt_d = memwait_cnt_q;
      if (state_d == ST_LDSTALL && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (state_d == ST_FLUSH && flush_cnt_q != CNT_MAX) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (state_d == ST_MEMWAIT && memwait_cnt_q != CNT_MAX) begin
         memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         memwait_cnt_q <= '0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         memwait_cnt_q <= memwait_cnt_d;
      end
   end

   assign stallCycles   = stall_cnt_q;
   assign flushCount    = flush_cnt_q;
   assign memWaitCycles = memwait_cnt_q;
`else
   assign stallCycles   = '0;
   assign flushCount    = '0;
   assign memWaitCycles = '0;
`endif

   assign pc           = pc_q;
   assign ifidInst     = ifid_inst_q;
   assign ifidPcPlus4  = ifid_pc_plus4_q;
   assign ifidValid    = ifid_valid_q;
   assign stateOut     = state_q;
   assign stallTimeout = timeout_q;
   assign bubble       = ~memBusy & (setZero | branchTaken);
   assign freeze       = memBusy;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: a behavioural front-end model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_pipeline_stall_controller;

   localparam int MAX_STALL = 15;
   localparam int CNT_MAX   = 65535;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_write = 1'b1;
   logic        ifid_write = 1'b1;
   logic        set_zero = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        mem_busy = 1'b0;
   logic [31:0] inst_in;
   logic [31:0] pc, ifid_inst, ifid_pc_plus4;
   logic        ifid_valid, bubble, freeze, stall_timeout;
   logic [1:0]  state_out;
   logic [15:0] stall_cycles, flush_count, mem_wait_cycles;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   // Instruction memory: every word encodes its own address.
   assign inst_in = {16'hC0DE, pc[15:0]};

   pipeline_stall_controller #(
      .RESET_PC (32'h0000_0000),
      .MAX_STALL(MAX_STALL),
      .CNT_W    (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .PCWrite      (pc_write),
      .IFIDWrite    (ifid_write),
      .setZero      (set_zero),
      .branchTaken  (branch_taken),
      .branchTarget (branch_target),
      .memBusy      (mem_busy),
      .instIn       (inst_in),
      .pc           (pc),
      .ifidInst     (ifid_inst),
      .ifidPcPlus4  (ifid_pc_plus4),
      .ifidValid    (ifid_valid),
      .bubble       (bubble),
      .freeze       (freeze),
      .stateOut     (state_out),
      .stallTimeout (stall_timeout),
      .stallCycles  (stall_cycles),
      .flushCount   (flush_count),
      .memWaitCycles(mem_wait_cycles)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_inst, m_pp4;
   logic        m_valid, m_to;
   int          m_state, m_run, m_stall, m_flush, m_mw;

   function automatic int sat(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc <= 32'h0; m_inst <= '0; m_pp4 <= '0; m_valid <= 1'b0;
         m_state <= 0; m_run <= 0; m_to <= 1'b0;
         m_stall <= 0; m_flush <= 0; m_mw <= 0;
      end else if (mem_busy) begin
         m_state <= 2; m_run <= 0; m_mw <= sat(m_mw);
      end else if (branch_taken) begin
         m_pc <= branch_target; m_inst <= '0; m_pp4 <= '0; m_valid <= 1'b0;
         m_state <= 3; m_run <= 0; m_flush <= sat(m_flush);
      end else if (!pc_write || !ifid_write) begin
         if (ifid_write) begin
            m_inst <= {16'hC0DE, m_pc[15:0]}; m_pp4 <= m_pc + 32'd4; m_valid <= 1'b1;
         end
         if (pc_write) m_pc <= m_pc + 32'd4;
         m_state <= 1;
         m_run   <= (m_run + 1 > MAX_STALL) ? MAX_STALL : m_run + 1;
         if (m_run + 1 >= MAX_STALL) m_to <= 1'b1;
         m_stall <= sat(m_stall);
      end else begin
         m_inst <= {16'hC0DE, m_pc[15:0]}; m_pp4 <= m_pc + 32'd4; m_valid <= 1'b1;
         m_pc <= m_pc + 32'd4; m_state <= 0; m_run <= 0;
      end
   end

   // Compare process: outputs are settled mid-cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_pc", pc, m_pc);
         check("m_ifid_inst", ifid_inst, m_inst);
         check("m_ifid_pp4", ifid_pc_plus4, m_pp4);
         check("m_ifid_valid", 32'(ifid_valid), 32'(m_valid));
         check("m_state", 32'(state_out), m_state);
         check("m_timeout", 32'(stall_timeout), 32'(m_to));
         check("m_bubble", 32'(bubble), 32'(~mem_busy & (set_zero | branch_taken)));
         check("m_freeze", 32'(freeze), 32'(mem_busy));
`ifdef PERF_CNT_EN
         check("m_stall_cnt", 32'(stall_cycles), m_stall);
         check("m_flush_cnt", 32'(flush_count), m_flush);
         check("m_mw_cnt", 32'(mem_wait_cycles), m_mw);
`else
         check("m_stall_cnt", 32'(stall_cycles), 32'd0);
         check("m_flush_cnt", 32'(flush_count), 32'd0);
         check("m_mw_cnt", 32'(mem_wait_cycles), 32'd0);
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic pw, input logic iw, input logic sz, input logic bt,
                        input logic [31:0] tgt, input logic mb);
      pc_write = pw; ifid_write = iw; set_zero = sz;
      branch_taken = bt; branch_target = tgt; mem_busy = mb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      cmp_en = 1'b1;
      check("rst_pc", pc, 32'h0);
      check("rst_valid", 32'(ifid_valid), 32'd0);
      check("rst_state", 32'(state_out), 32'd0);

      // Free-run from reset
      tick(); check("run_pc1", pc, 32'h4);
      check("run_ifid_valid", 32'(ifid_valid), 32'd1);
      check("run_ifid_pp4", ifid_pc_plus4, 32'h4);
      tick(); check("run_pc2", pc, 32'h8);
      tick(); check("run_pc3", pc, 32'hC);
      tick(); check("run_pc4", pc, 32'h10);

      // Load-use stall at pc=0x10
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1 check("ld_bubble", 32'(bubble), 32'd1);
      tick();
      check("ld_pc_hold", pc, 32'h10);
      check("ld_ifid_hold", ifid_pc_plus4, 32'h10);
      check("ld_ifid_inst", ifid_inst, 32'hC0DE_000C);
      check("ld_state", 32'(state_out), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); check("ld_resume_pc", pc, 32'h14);
      check("ld_resume_state", 32'(state_out), 32'd0);

      // Branch wins over concurrent stall
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
      #1 check("br_bubble", 32'(bubble), 32'd1);
      tick();
      check("br_pc", pc, 32'h40);
      check("br_valid", 32'(ifid_valid), 32'd0);
      check("br_state", 32'(state_out), 32'd3);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      check("br_fetch_inst", ifid_inst, 32'hC0DE_0040);
      check("br_fetch_valid", 32'(ifid_valid), 32'd1);

      // Memory wait with a pending branch held by EX
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("mw_freeze", 32'(freeze), 32'd1);
         check("mw_bubble", 32'(bubble), 32'd0);
         tick();
         check("mw_pc_hold", pc, 32'h44);
         check("mw_state", 32'(state_out), 32'd2);
      end
`ifdef PERF_CNT_EN
      check("mw_count", 32'(mem_wait_cycles), 32'd3);
`else
      check("mw_count_off", 32'(mem_wait_cycles), 32'd0);
`endif
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
      tick();
      check("mw_redirect", pc, 32'h80);
      check("mw_flush_state", 32'(state_out), 32'd3);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();

      // 14 stall cycles: no timeout
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      repeat (14) tick();
      check("to14_clear", 32'(stall_timeout), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();

      // 15 stall cycles: timeout on the 15th edge
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 14) check("to15_before", 32'(stall_timeout), 32'd0);
      end
      check("to15_set", 32'(stall_timeout), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); tick();
      check("to_sticky", 32'(stall_timeout), 32'd1);

      // PC wrap
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      tick();
      check("wrap_pre", pc, 32'hFFFF_FFFC);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      check("wrap_pc", pc, 32'h0);
      check("wrap_pp4", ifid_pc_plus4, 32'h0);

      // Async reset in the middle of a load-use stall
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      check("ar_in_stall", 32'(state_out), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("ar_pc", pc, 32'h0);
      check("ar_state", 32'(state_out), 32'd0);
      check("ar_valid", 32'(ifid_valid), 32'd0);
      check("ar_timeout", 32'(stall_timeout), 32'd0);
      check("ar_pp4", ifid_pc_plus4, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      #3 rst = 1'b1;
      tick(); check("ar_restart_pc", pc, 32'h4);
      tick(); tick();

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Front-end pipeline controller for the 5-stage MIPS core. It owns the PC register and the IF/ID pipeline register, and it acts on the control signals produced by the hazard unit:
- load-use stall requests (`PCWrite`/`IFIDWrite`/`setZero`);
- branch/jump redirects from EX;
- multi-cycle data-memory wait.

It sequences these through a small state machine, emits the ID/EX bubble and freeze controls, and tracks stall health.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset
- `MAX_STALL`, 15, consecutive load-use stall cycles before `stallTimeout` sets
- `CNT_W`, 16, width of performance counters

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `PCWrite`  in  1  from hazard unit; 0 = hold PC
- `IFIDWrite`  in  1  from hazard unit; 0 = hold IF/ID
- `setZero`  in  1  from hazard unit; 1 = zero ID/EX controls
- `branchTaken`  in  1  redirect request from EX (branch or jump)
- `branchTarget`  in  32  redirect address
- `memBusy`  in  1  data memory not ready; freeze the whole pipeline
- `instIn`  in  32  instruction fetched at `pc`
- `pc`  out  32  current fetch address
- `ifidInst`  out  32  IF/ID instruction
- `ifidPcPlus4`  out  32  IF/ID PC+4
- `ifidValid`  out  1  IF/ID holds a real instruction
- `bubble`  out  1  zero ID/EX control word this cycle
- `freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB this cycle
- `stateOut`  out  2  RUN=0, LDSTALL=1, MEMWAIT=2, FLUSH=3
- `stallTimeout`  out  1  sticky error flag
- `stallCycles`, `flushCount`, `memWaitCycles`  out  `CNT_W` each  performance counters

## Operation
Reset values (on `rst`=0, asynchronous):
- `pc`=`RESET_PC`
- `ifidInst`=0, `ifidPcPlus4`=0, `ifidValid`=0
- state=RUN, `stallTimeout`=0
- run-length counter and all performance counters = 0

Per rising edge, conditions are evaluated in strict priority order:
1. **`memBusy`=1:** PC and IF/ID hold. State → MEMWAIT. All other requests, including `branchTaken`, are ignored this cycle. EX must keep `branchTaken` asserted until `memBusy` drops.
2. **`branchTaken`=1:** `pc` ← `branchTarget`. IF/ID ← {inst 0, PC+4 0, valid 0}. State → FLUSH. Any concurrent load-use request is discarded.
3. **`PCWrite`=0 or `IFIDWrite`=0:** each signal acts independently.
   - `PCWrite`=0 holds `pc`; otherwise `pc` ← `pc`+4.
   - `IFIDWrite`=0 holds IF/ID; otherwise IF/ID ← {`instIn`, `pc`+4, 1}.
   - State → LDSTALL.
4. **Otherwise:** `pc` ← `pc`+4. IF/ID ← {`instIn`, `pc`+4, 1}. State → RUN.

Combinational outputs:
- `bubble` = ~`memBusy` & (`setZero` | `branchTaken`)
- `freeze` = `memBusy`

Arithmetic and counters:
- `pc`+4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 0.
- **Run-length counter:** increments on each cycle that enters LDSTALL, saturates at `MAX_STALL`, and clears on any cycle that does not enter LDSTALL. MEMWAIT cycles also clear it.
- `stallTimeout` sets on the edge where the run-length counter reaches `MAX_STALL`. It stays set until reset.

## Timing
- PC, IF/ID, state and counters are registered, with 1-cycle latency from request to effect.
- `bubble` and `freeze` are combinational, with zero latency, and are valid in the same cycle as their inputs.
- After a redirect, the fetch at `branchTarget` appears in IF/ID two edges after `branchTaken` was sampled. One FLUSH cycle shows `ifidValid`=0 in between.
- A load-use stall lasts exactly as long as the hazard unit holds its request. With no memory wait, a normal load-use case lasts 1 cycle.
- Reset asserted mid-stall or mid-flush returns all state to reset values immediately. No pending redirect survives reset.

## Configuration
`PERF_CNT_EN` controls the performance counters.
- **Defined:**
  - `stallCycles` counts edges entering LDSTALL.
  - `flushCount` counts edges entering FLUSH.
  - `memWaitCycles` counts edges entering MEMWAIT.
  - All three saturate at 2^`CNT_W`−1 and clear only on reset.
- **Undefined:** the three counter outputs are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- **Reset then free-run:** `rst` low, then high, `RESET_PC`=0, no requests → `pc` = 0, 4, 8, 12 on successive edges; IF/ID follows one edge behind with `ifidValid`=1 after the first edge.
- **Load-use stall:** `PCWrite`=`IFIDWrite`=0, `setZero`=1 for 1 cycle at `pc`=0x10 → `pc` stays 0x10, IF/ID holds, `bubble`=1, `stateOut`=1; next edge `pc`=0x14.
- **Branch over stall:** `branchTaken`=1 with target 0x40 plus concurrent `PCWrite`=0 → `pc`=0x40, `ifidValid`=0, `stateOut`=3, `bubble`=1.
- **Memory wait:** `memBusy`=1 for 3 cycles with concurrent `branchTaken`=1 → `freeze`=1, `bubble`=0, `pc` unchanged for 3 edges; redirect to target on the first edge after `memBusy` drops. With `PERF_CNT_EN` defined, `memWaitCycles`=3.
- **Stall timeout:** hold `PCWrite`=0 for 15 cycles with `MAX_STALL`=15 → `stallTimeout` rises on the 15th edge and stays 1 after the requests clear. With 14 cycles it stays 0.
- **Wrap and async reset:** `pc`=0xFFFF_FFFC free-run → next `pc`=0. Assert `rst` low between edges during LDSTALL → all outputs are at reset values immediately.
